// File: rtl/parity_accum_engine.sv
// ============================================================================
// Module      : parity_accum_engine
// Description : QC-LDPC parity accumulator. Streams message chunks against
//               circulant first rows and drains the M-bit parity in LM chunks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_accum_engine #(
  parameter int LM   = 16,
  parameter int M    = 32,
  parameter int KMAX = 8,
  parameter int KW   = $clog2(KMAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [KW-1:0] num_blk_i,
  input  logic          g_valid_i,
  output logic          g_ready_o,
  input  logic [M-1:0]  g_data_i,
  input  logic          msg_valid_i,
  output logic          msg_ready_o,
  input  logic [LM-1:0] msg_data_i,
  output logic          par_valid_o,
  input  logic          par_ready_i,
  output logic [LM-1:0] par_data_o,
  output logic          par_last_o,
  output logic          busy_o,
  output logic          err_o
);

  localparam int NCH = M / LM;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCH - 1);
  localparam logic [KW-1:0] KMAX_C     = KW'(KMAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ACCUM = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [M-1:0]  r_q, r_d;
  logic [M-1:0]  p_q, p_d;
  logic [KW-1:0] blk_q, blk_d;
  logic [KW-1:0] nblk_q, nblk_d;
  logic [CW-1:0] chunk_q, chunk_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          err_d;
  logic [M-1:0]  contrib;

  logic          g_ready_q, msg_ready_q, par_valid_q, par_last_q, busy_q, err_q;
  logic [LM-1:0] par_data_q;

  // Bit c of the result takes bit (c - s) mod M of x.
  function automatic logic [M-1:0] rotr(input logic [M-1:0] x, input int s);
    logic [2*M-1:0] t;
    t = {x, x} << s;
    return t[2*M-1:M];
  endfunction

  always_comb begin
    contrib = '0;
    for (int j = 0; j < LM; j++) begin
      if (msg_data_i[j]) contrib = contrib ^ rotr(r_q, j);
    end
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    p_d     = p_q;
    blk_d   = blk_q;
    nblk_d  = nblk_q;
    chunk_d = chunk_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (num_blk_i != '0 && num_blk_i <= KMAX_C) begin
            nblk_d  = num_blk_i;
            p_d     = '0;
            blk_d   = '0;
            state_d = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (g_valid_i && g_ready_q) begin
          r_d     = g_data_i;
          chunk_d = '0;
          state_d = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (msg_valid_i && msg_ready_q) begin
          p_d     = p_q ^ contrib;
          r_d     = rotr(r_q, LM);
          chunk_d = chunk_q + CW'(1);
          if (chunk_q == LAST_CHUNK) begin
            if (blk_q == nblk_q - KW'(1)) begin
              idx_d   = '0;
              state_d = S_OUT;
            end else begin
              blk_d   = blk_q + KW'(1);
              state_d = S_LOAD;
            end
          end
        end
      end
      S_OUT: begin
        if (par_ready_i && par_valid_q) begin
          idx_d = idx_q + CW'(1);
          if (idx_q == LAST_CHUNK) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state view so they align with state_q.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      r_q         <= '0;
      p_q         <= '0;
      blk_q       <= '0;
      nblk_q      <= '0;
      chunk_q     <= '0;
      idx_q       <= '0;
      g_ready_q   <= 1'b0;
      msg_ready_q <= 1'b0;
      par_valid_q <= 1'b0;
      par_last_q  <= 1'b0;
      par_data_q  <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_q         <= r_d;
      p_q         <= p_d;
      blk_q       <= blk_d;
      nblk_q      <= nblk_d;
      chunk_q     <= chunk_d;
      idx_q       <= idx_d;
      g_ready_q   <= (state_d == S_LOAD);
      msg_ready_q <= (state_d == S_ACCUM);
      par_valid_q <= (state_d == S_OUT);
      par_last_q  <= (state_d == S_OUT) && (idx_d == LAST_CHUNK);
      par_data_q  <= (state_d == S_OUT) ? p_d[idx_d*LM +: LM] : '0;
      busy_q      <= (state_d != S_IDLE);
      err_q       <= err_d;
    end
  end

  assign g_ready_o   = g_ready_q;
  assign msg_ready_o = msg_ready_q;
  assign par_valid_o = par_valid_q;
  assign par_last_o  = par_last_q;
  assign par_data_o  = par_data_q;
  assign busy_o      = busy_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_parity_accum_engine.sv
// ============================================================================
// Module      : tb_parity_accum_engine
// Description : Scoreboard bench for parity_accum_engine with random codewords.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_accum_engine;

  localparam int LM   = 16;
  localparam int M    = 32;
  localparam int KMAX = 8;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int NCH  = M / LM;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic [KW-1:0] num_blk_i = '0;
  logic          g_valid_i = 1'b0;
  logic          g_ready_o;
  logic [M-1:0]  g_data_i = '0;
  logic          msg_valid_i = 1'b0;
  logic          msg_ready_o;
  logic [LM-1:0] msg_data_i = '0;
  logic          par_valid_o;
  logic          par_ready_i = 1'b1;
  logic [LM-1:0] par_data_o;
  logic          par_last_o;
  logic          busy_o;
  logic          err_o;

  parity_accum_engine #(.LM(LM), .M(M), .KMAX(KMAX), .KW(KW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start_i),
    .num_blk_i   (num_blk_i),
    .g_valid_i   (g_valid_i),
    .g_ready_o   (g_ready_o),
    .g_data_i    (g_data_i),
    .msg_valid_i (msg_valid_i),
    .msg_ready_o (msg_ready_o),
    .msg_data_i  (msg_data_i),
    .par_valid_o (par_valid_o),
    .par_ready_i (par_ready_i),
    .par_data_o  (par_data_o),
    .par_last_o  (par_last_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [LM-1:0] data;
    logic          last;
  } exp_t;

  exp_t         exp_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;
  bit           gap_en  = 1'b0;
  int           ready_mode = 0;
  int           hold_cnt   = 0;
  logic [M-1:0] g_arr [KMAX];
  logic [M-1:0] m_arr [KMAX];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: sum over blocks and rows of msg bit r times the circulant row r.
  function automatic logic [M-1:0] model(input int nb);
    logic [M-1:0] p;
    p = '0;
    for (int b = 0; b < nb; b++)
      for (int r = 0; r < M; r++)
        if (m_arr[b][r])
          for (int c = 0; c < M; c++)
            p[c] = p[c] ^ g_arr[b][(c - r + M) % M];
    return p;
  endfunction

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy_o && t < 300) begin
      step();
      t++;
    end
    check("busy_falls", {63'd0, busy_o}, 64'd0);
  endtask

  task automatic send_g(input logic [M-1:0] g);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    if (gap_en) repeat (2) step();
    g_valid_i = 1'b1;
    g_data_i  = g;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = g_ready_o;
      step();
      t++;
    end
    g_valid_i = 1'b0;
    g_data_i  = $urandom;
    if (!hs) check("g_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_msg(input logic [LM-1:0] d);
    bit hs;
    int t;
    hs = 1'b0;
    t  = 0;
    if (gap_en) repeat (2) step();
    msg_valid_i = 1'b1;
    msg_data_i  = d;
    while (!hs && t < 100) begin
      @(negedge clk);
      hs = msg_ready_o;
      step();
      t++;
    end
    msg_valid_i = 1'b0;
    msg_data_i  = LM'($urandom);
    if (!hs) check("msg_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_codeword(input int nb, input bit busy_start);
    logic [M-1:0] p;
    wait_idle();
    start_i   = 1'b1;
    num_blk_i = KW'(nb);
    step();
    start_i   = 1'b0;
    num_blk_i = KW'($urandom);
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    for (int b = 0; b < nb; b++) begin
      send_g(g_arr[b]);
      if (busy_start && b == 0) begin
        start_i   = 1'b1;
        num_blk_i = KW'(2);
        step();
        start_i = 1'b0;
        step();
        check("busy_start_no_err", {62'd0, err_o, busy_o}, 64'd1);
      end
      for (int k = 0; k < NCH; k++) send_msg(m_arr[b][k*LM +: LM]);
    end
    check("par_valid_after_last_msg", {63'd0, par_valid_o}, 64'd1);
    p = model(nb);
    for (int i = 0; i < NCH; i++) exp_q.push_back('{data: p[i*LM +: LM], last: (i == NCH - 1)});
  endtask

  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: par_ready_i = 1'b1;
        1: par_ready_i = 1'($urandom_range(0, 1));
        default: begin
          if (par_valid_o && hold_cnt < 3) begin
            par_ready_i = 1'b0;
            hold_cnt++;
          end else begin
            par_ready_i = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin : monitor
    bit            held;
    logic [LM-1:0] held_data;
    exp_t          e;
    held = 1'b0;
    held_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && par_valid_o) begin
        if (held) check("par_hold_stable", {48'd0, par_data_o}, {48'd0, held_data});
        if (par_ready_i) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            check("par_unexpected", 64'd1, 64'd0);
          end else begin
            e = exp_q.pop_front();
            check("par_data", {48'd0, par_data_o}, {48'd0, e.data});
            check("par_last", {63'd0, par_last_o}, {63'd0, e.last});
          end
        end else begin
          held      = 1'b1;
          held_data = par_data_o;
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int t;
    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {g_ready_o, msg_ready_o, par_valid_o, par_last_o, busy_o, err_o, par_data_o},
          64'd0);
    rst_n = 1'b1;
    repeat (3) step();
    check("idle_outputs", {g_ready_o, msg_ready_o, par_valid_o, par_last_o, busy_o, err_o, par_data_o},
          64'd0);

    // Identity circulant
    g_arr[0] = 32'h0000_0001;
    m_arr[0] = {16'h1234, 16'hBEEF};
    run_codeword(1, 1'b0);
    wait_idle();

    // Wrap-around
    g_arr[0] = 32'h8000_0000;
    m_arr[0] = {16'h0000, 16'h0003};
    run_codeword(1, 1'b0);

    // Multi-block cancellation, then shifted second block
    g_arr[0] = 32'h0000_0001;
    g_arr[1] = 32'h0000_0001;
    m_arr[0] = {16'h5A5A, 16'hA5A5};
    m_arr[1] = {16'h5A5A, 16'hA5A5};
    run_codeword(2, 1'b0);
    g_arr[1] = 32'h0000_0002;
    run_codeword(2, 1'b0);

    // Back-pressure, stalls and start while busy
    wait_idle();
    gap_en     = 1'b1;
    hold_cnt   = 0;
    ready_mode = 2;
    run_codeword(2, 1'b1);
    wait_idle();
    gap_en     = 1'b0;
    ready_mode = 0;

    // Illegal starts
    for (int i = 0; i < 2; i++) begin
      start_i   = 1'b1;
      num_blk_i = (i == 0) ? KW'(0) : KW'(KMAX + 1);
      step();
      start_i = 1'b0;
      check("err_pulse", {62'd0, err_o, busy_o}, 64'd2);
      step();
      check("err_one_cycle", {62'd0, err_o, busy_o}, 64'd0);
    end

    // Reset during ACCUM
    start_i   = 1'b1;
    num_blk_i = KW'(1);
    step();
    start_i = 1'b0;
    send_g(32'hDEAD_BEEF);
    send_msg(16'hFFFF);
    rst_n = 1'b0;
    #1;
    check("abort_idle", {61'd0, busy_o, msg_ready_o, par_valid_o}, 64'd0);
    step();
    rst_n = 1'b1;
    step();
    g_arr[0] = 32'h0000_0001;
    m_arr[0] = {16'h0F0F, 16'h00FF};
    run_codeword(1, 1'b0);

    // Randomized codewords
    for (int n = 0; n < 20; n++) begin
      int nb;
      nb = $urandom_range(1, KMAX);
      for (int b = 0; b < KMAX; b++) begin
        g_arr[b] = $urandom;
        m_arr[b] = $urandom;
      end
      gap_en     = 1'($urandom_range(0, 1));
      ready_mode = 1;
      run_codeword(nb, 1'($urandom_range(0, 1)));
    end

    t = 0;
    while (exp_q.size() != 0 && t < 1000) begin
      step();
      t++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
